// File: rtl/ex_muldiv_unit_if.sv
// rtl/ex_muldiv_unit_if.sv - request/response handshake bundle between the EX stage and the mul/div unit
interface ex_muldiv_unit_if #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         op;
    logic [XLEN-1:0]    rs1;
    logic [XLEN-1:0]    rs2;
    logic [RADDR_W-1:0] rd_in;
    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    result;
    logic [RADDR_W-1:0] rd_out;
    logic               busy;

    modport master (
        output in_valid, op, rs1, rs2, rd_in, out_ready,
        input  in_ready, out_valid, result, rd_out, busy
    );

    modport slave (
        input  in_valid, op, rs1, rs2, rd_in, out_ready,
        output in_ready, out_valid, result, rd_out, busy
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative RV32M multiply/divide unit; MULDIV_FAST_MUL_EN selects a single-cycle multiplier
module ex_muldiv_unit #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    ex_muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam int AW = 2 * XLEN + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [2:0]         op_q;
    logic               neg_q;
    logic [XLEN-1:0]    opb_q;
    logic [AW-1:0]      acc;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;
    logic [XLEN-1:0]    result_q;
    logic [RADDR_W-1:0] rd_q;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.result    = result_q;
    assign bus.rd_out    = rd_q;

    // Accept-time decode: operand signedness, magnitudes, result sign and fast-path cases.
    logic            rs1_sgn, rs2_sgn, rs1_neg, rs2_neg, neg_in;
    logic [XLEN-1:0] mag1, mag2;
    logic            div_zero, div_ovf, mul_zero, special;
    logic [XLEN-1:0] special_res;

    always_comb begin
        rs1_sgn     = ~(bus.op[0] & (bus.op[1] | bus.op[2]));
        rs2_sgn     = rs1_sgn & (bus.op != 3'b010);
        rs1_neg     = rs1_sgn & bus.rs1[XLEN-1];
        rs2_neg     = rs2_sgn & bus.rs2[XLEN-1];
        neg_in      = (bus.op[2] & bus.op[1]) ? rs1_neg : (rs1_neg ^ rs2_neg);
        mag1        = rs1_neg ? (~bus.rs1 + XLEN'(1)) : bus.rs1;
        mag2        = rs2_neg ? (~bus.rs2 + XLEN'(1)) : bus.rs2;
        div_zero    = bus.op[2] & (bus.rs2 == '0);
        div_ovf     = bus.op[2] & ~bus.op[0] & (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}})
                      & (bus.rs2 == '1);
        mul_zero    = ~bus.op[2] & ((bus.rs1 == '0) | (bus.rs2 == '0));
        special     = div_zero | div_ovf | mul_zero;
        special_res = '0;
        if (div_zero)
            special_res = bus.op[1] ? bus.rs1 : '1;
        else if (div_ovf)
            special_res = bus.op[1] ? '0 : bus.rs1;
    end

    // Divide step: acc = {spare, remainder, dividend/quotient}; shift in one dividend bit and try to subtract.
    logic [XLEN:0]   div_sh, div_rem;
    logic            div_ge;
    logic [AW-1:0]   div_next;
    logic [XLEN-1:0] quo, rem, div_res;

    always_comb begin
        div_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_ge   = div_sh >= {1'b0, opb_q};
        div_rem  = div_ge ? (div_sh - {1'b0, opb_q}) : div_sh;
        div_next = {div_rem, acc[XLEN-2:0], div_ge};
        quo      = div_next[XLEN-1:0];
        rem      = div_next[2*XLEN-1:XLEN];
        if (op_q[1])
            div_res = neg_q ? (~rem + XLEN'(1)) : rem;
        else
            div_res = neg_q ? (~quo + XLEN'(1)) : quo;
    end

    logic [2*XLEN-1:0] prod_raw, prod;
    logic [XLEN-1:0]   mul_res;

`ifdef MULDIV_FAST_MUL_EN
    always_comb begin
        prod_raw = {{XLEN{1'b0}}, opb_q} * {{XLEN{1'b0}}, acc[XLEN-1:0]};
    end
`else
    // Shift-add step: acc = {carry, high product, multiplier}; add the multiplicand on LSB, then shift right.
    logic [XLEN:0] mul_sum;
    logic [AW-1:0] mul_next;

    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opb_q};
        mul_next = acc[0] ? {1'b0, mul_sum, acc[XLEN-1:1]} : {1'b0, acc[AW-1:1]};
        prod_raw = mul_next[2*XLEN-1:0];
    end
`endif

    always_comb begin
        prod    = neg_q ? (~prod_raw + (2*XLEN)'(1)) : prod_raw;
        mul_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            op_q        <= '0;
            neg_q       <= 1'b0;
            opb_q       <= '0;
            acc         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            result_q    <= '0;
            rd_q        <= '0;
        end else if (flush) begin
            state       <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        op_q       <= bus.op;
                        rd_q       <= bus.rd_in;
                        neg_q      <= neg_in;
                        cnt        <= CW'(XLEN);
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (special) begin
                            state       <= S_DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= special_res;
                        end else if (bus.op[2]) begin
                            state <= S_DIV;
                            opb_q <= mag2;
                            acc   <= {{(XLEN+1){1'b0}}, mag1};
                        end else begin
                            state <= S_MUL;
                            opb_q <= mag1;
                            acc   <= {{(XLEN+1){1'b0}}, mag2};
                        end
                    end
                end
                S_MUL: begin
`ifdef MULDIV_FAST_MUL_EN
                    state       <= S_DONE;
                    out_valid_q <= 1'b1;
                    result_q    <= mul_res;
`else
                    acc <= mul_next;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state       <= S_DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= mul_res;
                    end
`endif
                end
                S_DIV: begin
                    acc <= div_next;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state       <= S_DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= div_res;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state       <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - scoreboard bench for ex_muldiv_unit
module tb_ex_muldiv_unit;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic clk, rst, flush;
    ex_muldiv_unit_if #(.XLEN(32), .RADDR_W(5)) bus ();

    ex_muldiv_unit #(.XLEN(32), .RADDR_W(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sbb, ua;
        logic [63:0] p;
        logic ovf;
        sa  = longint'($signed(a));
        sbb = longint'($signed(b));
        ua  = longint'({32'd0, a});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (o)
            3'd0: begin p = sa * sbb; return p[31:0]; end
            3'd1: begin p = sa * sbb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sbb);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sbb);
            default: return (b == 0) ? a : (ua == 0 ? 32'd0 : a % b);
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o[2] && (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
        if (!o[2] && (a == 0 || b == 0)) return 1;
        return o[2] ? DIV_LAT : MUL_LAT;
    endfunction

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r, input logic [31:0] res, input int lat);
        exp_t e;
        @(negedge clk);
        chk("in_ready_before_issue", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.op = o; bus.rs1 = a; bus.rs2 = b; bus.rd_in = r;
        e.res = res; e.rd = r; e.lat = lat;
        sb.push_back(e);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic collect(input string tag);
        exp_t e;
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (n < 100 && !seen) begin
            @(negedge clk);
            n++;
            seen = bus.out_valid;
        end
        e = sb.pop_front();
        chk({tag, "_valid"}, seen, 1);
        chk({tag, "_lat"}, n, e.lat);
        chk({tag, "_res"}, bus.result, e.res);
        chk({tag, "_rd"}, bus.rd_out, e.rd);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_idle_out_valid"}, bus.out_valid, 0);
        chk({tag, "_idle_in_ready"}, bus.in_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  o;
        logic [31:0] a, b, hold_res;
        logic [4:0]  hold_rd;
        int          n;
        bit          seen;

        rst = 1'b1; flush = 1'b0;
        bus.in_valid = 1'b0; bus.op = '0; bus.rs1 = '0; bus.rs2 = '0; bus.rd_in = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_rd_out", bus.rd_out, 0);

        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, MUL_LAT);       collect("mul");
        issue(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, MUL_LAT); collect("mulh");
        issue(3'd3, 32'h8000_0000, 32'h8000_0000, 5'd7, 32'h4000_0000, MUL_LAT); collect("mulhu");
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFF, MUL_LAT); collect("mulhsu");
        issue(3'd4, 32'hFFFF_FFEC, 32'd3, 5'd9, 32'hFFFF_FFFA, DIV_LAT);         collect("div");
        issue(3'd6, 32'hFFFF_FFEC, 32'd3, 5'd10, 32'hFFFF_FFFE, DIV_LAT);        collect("rem");
        issue(3'd5, 32'd100, 32'd7, 5'd11, 32'd14, DIV_LAT);                     collect("divu");
        issue(3'd7, 32'd100, 32'd7, 5'd12, 32'd2, DIV_LAT);                      collect("remu");
        issue(3'd5, 32'd9, 32'd0, 5'd13, 32'hFFFF_FFFF, 1);                      collect("divu_zero");
        issue(3'd6, 32'd9, 32'd0, 5'd14, 32'd9, 1);                              collect("rem_zero");
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1);      collect("div_ovf");
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0, 1);              collect("rem_ovf");
        issue(3'd0, 32'd0, 32'd5, 5'd17, 32'd0, 1);                              collect("mul_zero");

        for (int i = 0; i < 8; i++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            b = (i % 3 == 0) ? 32'd0 : $urandom;
            if (i == 5) a = 32'd0;
            issue(o, a, b, 5'(i + 20), model(o, a, b), model_lat(o, a, b));
            collect("rand");
        end

        // Result must be held while the consumer stalls.
        issue(3'd5, 32'd100, 32'd7, 5'd3, 32'd14, DIV_LAT);
        n = 0; seen = 1'b0;
        while (n < 100 && !seen) begin
            @(negedge clk);
            n++;
            seen = bus.out_valid;
        end
        chk("hold_valid", seen, 1);
        void'(sb.pop_front());
        hold_res = 32'd14;
        hold_rd  = 5'd3;
        repeat (10) begin
            @(negedge clk);
            chk("hold_out_valid", bus.out_valid, 1);
            chk("hold_result", bus.result, hold_res);
            chk("hold_rd_out", bus.rd_out, hold_rd);
            chk("hold_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        chk("release_in_ready", bus.in_ready, 1);
        chk("release_out_valid", bus.out_valid, 0);
        chk("release_busy", bus.busy, 0);

        // Flush coinciding with a request in IDLE blocks the accept.
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = 3'd5; bus.rs1 = 32'd50; bus.rs2 = 32'd5; flush = 1'b1;
        @(posedge clk);
        #1 begin bus.in_valid = 1'b0; flush = 1'b0; end
        @(negedge clk);
        chk("idle_flush_busy", bus.busy, 0);
        chk("idle_flush_in_ready", bus.in_ready, 1);

        // Flush mid-divide discards the result.
        issue(3'd4, 32'd1000, 32'd7, 5'd4, 32'd142, DIV_LAT);
        repeat (11) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_in_ready", bus.in_ready, 1);
        chk("flush_out_valid", bus.out_valid, 0);
        chk("flush_busy", bus.busy, 0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen = seen | bus.out_valid;
        end
        chk("flush_never_valid", seen, 0);
        sb.delete();

        // Reset mid-multiply.
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, MUL_LAT);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", bus.in_ready, 1);
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_result", bus.result, 0);
        chk("midrst_rd_out", bus.rd_out, 0);
        sb.delete();

        issue(3'd7, 32'd100, 32'd7, 5'd1, 32'd2, DIV_LAT);
        collect("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
